// File: rtl/conv1_output_serializer.sv
// Vector-to-stream serializer for conv1 results: accepted CH-channel vectors queue in a
// small FIFO and leave one channel per handshake, vector-major, NUM_VEC vectors per frame.
module conv1_output_serializer #(
  parameter int DW      = 16,
  parameter int CH      = 4,
  parameter int DEPTH   = 4,
  parameter int NUM_VEC = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ivalid,
  input  logic [DW-1:0] iy0,
  input  logic [DW-1:0] iy1,
  input  logic [DW-1:0] iy2,
  input  logic [DW-1:0] iy3,
  input  logic [DW-1:0] iy4,
  input  logic [DW-1:0] iy5,
  input  logic [DW-1:0] iy6,
  input  logic [DW-1:0] iy7,
  output logic          iready,
  output logic [DW-1:0] odata,
  output logic          ovalid,
  input  logic          oready,
  output logic          olast,
  output logic          done
);

  localparam int CW = $clog2(CH);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(NUM_VEC + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    in_cnt_q, in_cnt_d;
  logic [IW-1:0]    vec_cnt_q, vec_cnt_d;
  logic [CW-1:0]    ch_cnt_q, ch_cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;

  // Channel ports above CH are accepted but never stored.
  logic [7:0][DW-1:0]    iy_all;
  logic [CH-1:0][DW-1:0] iy_vec;
  logic                  unused_iy;
  assign iy_all    = {iy7, iy6, iy5, iy4, iy3, iy2, iy1, iy0};
  assign iy_vec    = iy_all[CH-1:0];
  assign unused_iy = ^iy_all;

  logic [CH-1:0][DW-1:0] mem_q [DEPTH];

  logic run, full, empty, push, xfer, ch_last, pop;
  assign run     = (state_q == RUN) && start;
  assign full    = (fill_q == FW'(DEPTH));
  assign empty   = (fill_q == '0);
  assign ch_last = (ch_cnt_q == CW'(CH - 1));

  assign iready  = run && !full && (in_cnt_q < IW'(NUM_VEC));
  assign ovalid  = run && !empty;
  assign olast   = ovalid && (vec_cnt_q == IW'(NUM_VEC - 1)) && ch_last;
  assign odata   = empty ? '0 : mem_q[rd_ptr_q][ch_cnt_q];
  assign done    = (state_q == DONE);

  assign push = ivalid && iready;
  assign xfer = ovalid && oready;
  assign pop  = xfer && ch_last;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    vec_cnt_d = vec_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          in_cnt_d = in_cnt_q + IW'(1);
        end
        if (xfer) begin
          if (ch_last) begin
            ch_cnt_d  = '0;
            rd_ptr_d  = rd_ptr_q + PW'(1);
            vec_cnt_d = vec_cnt_q + IW'(1);
          end else begin
            ch_cnt_d  = ch_cnt_q + CW'(1);
          end
        end
        case ({push, pop})
          2'b10:   fill_d = fill_q + FW'(1);
          2'b01:   fill_d = fill_q - FW'(1);
          default: fill_d = fill_q;
        endcase
        if (xfer && olast) state_d = DONE;
      end
      DONE: begin
        state_d   = IDLE;
        in_cnt_d  = '0;
        vec_cnt_d = '0;
        ch_cnt_d  = '0;
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        fill_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      vec_cnt_q <= '0;
      ch_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
    end
  end

  // Storage is not reset; odata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= iy_vec;
  end

endmodule
